// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - signed restoring shift-subtract divider with start/ready handshake
module booth_divider #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] Dividend,
  input  logic [WORD_LENGTH-1:0] Divisor,
  output logic                   ready,
  output logic [WORD_LENGTH-1:0] Quotient,
  output logic [WORD_LENGTH-1:0] Remainder,
  output logic                   Sign,
  output logic                   DivByZero,
  output logic                   Overflow
);

  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIX} state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [W-1:0]   r_q;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_div;
  logic [W-1:0]   r_dividend;
  logic [CW-1:0]  r_cnt;
  logic           r_sa;
  logic           r_sb;
  logic           r_dbz;
  logic           r_ovf;

  logic [W-1:0]   r_quotient;
  logic [W-1:0]   r_remainder;
  logic           r_sign;
  logic           r_dbz_o;
  logic           r_ovf_o;

  logic [W-1:0]   w_abs_dd;
  logic [W-1:0]   w_abs_ds;
  logic           w_div_zero;
  logic           w_ovf_in;
  logic [W:0]     w_shift_rem;
  logic [W:0]     w_trial;
  logic           w_fits;
  logic           w_last;

  // W-bit unsigned magnitude is exact even for -2^(W-1), which maps to 2^(W-1).
  assign w_abs_dd    = Dividend[W-1] ? (~Dividend + 1'b1) : Dividend;
  assign w_abs_ds    = Divisor[W-1]  ? (~Divisor  + 1'b1) : Divisor;
  assign w_div_zero  = (Divisor == '0);
  assign w_ovf_in    = (Dividend == {1'b1, {(W-1){1'b0}}}) && (Divisor == '1);

  assign w_shift_rem = {r_rem, r_q[W-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_div};
  assign w_fits      = ~w_trial[W];
  assign w_last      = (r_cnt == CW'(W - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = w_div_zero ? S_FIX : S_DIVIDE;
      S_DIVIDE: if (w_last) w_state_next = S_FIX;
      S_FIX:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_dividend  <= '0;
      r_cnt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_sign      <= 1'b0;
      r_dbz_o     <= 1'b0;
      r_ovf_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_q        <= w_abs_dd;
          r_div      <= w_abs_ds;
          r_dividend <= Dividend;
          r_rem      <= '0;
          r_cnt      <= '0;
          r_sa       <= Dividend[W-1];
          r_sb       <= Divisor[W-1];
          r_dbz      <= w_div_zero;
          r_ovf      <= w_ovf_in;
        end
        S_DIVIDE: begin
          r_rem <= w_fits ? w_trial[W-1:0] : w_shift_rem[W-1:0];
          r_q   <= {r_q[W-2:0], w_fits};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_sign  <= r_sa ^ r_sb;
          r_dbz_o <= r_dbz;
          r_ovf_o <= r_ovf;
          if (r_dbz) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
          end else begin
            r_quotient  <= (r_sa ^ r_sb) ? (~r_q + 1'b1) : r_q;
            r_remainder <= r_sa ? (~r_rem + 1'b1) : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign Sign      = r_sign;
  assign DivByZero = r_dbz_o;
  assign Overflow  = r_ovf_o;

endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - directed self-checking bench for booth_divider
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] Dividend;
  logic [15:0] Divisor;
  logic        ready;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Sign;
  logic        DivByZero;
  logic        Overflow;

  int n_cmp = 0;
  int n_bad = 0;

  booth_divider #(.WORD_LENGTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .ready     (ready),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Sign      (Sign),
    .DivByZero (DivByZero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [15:0] q, input logic [15:0] r,
                              input logic s, input logic dz, input logic ov);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"},   Quotient, q);
    check({tag, ".r"},   Remainder, r);
    check({tag, ".sign"}, Sign, s);
    check({tag, ".dbz"}, DivByZero, dz);
    check({tag, ".ovf"}, Overflow, ov);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] q, input logic [15:0] r,
                         input logic s, input logic dz, input logic ov);
    int lat;
    @(negedge clk);
    Dividend = a; Divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    Dividend = ~a; Divisor = 16'h0001;
    check({tag, ".busy"}, ready, 1'b0);
    wait_ready(lat);
    check_result(tag, lat, exp_lat, q, r, s, dz, ov);
  endtask

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        s;
  } vec_t;

  vec_t b2b[3];

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", ready, 1'b1);
    check("rst.outs", {Quotient, Remainder}, 32'h0);
    check("rst.flags", {Sign, DivByZero, Overflow}, 3'b000);
    @(negedge clk); reset = 1'b0;

    run_div("100/7",     16'd100,  16'd7,      17, 16'd14,   16'd2,    1'b0, 1'b0, 1'b0);
    run_div("-32760/2",  16'h8008, 16'd2,      17, 16'hC004, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_div("-7/2",      16'hFFF9, 16'd2,      17, 16'hFFFD, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_div("7/-2",      16'd7,    16'hFFFE,   17, 16'hFFFD, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_div("-7/-2",     16'hFFF9, 16'hFFFE,   17, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_div("min/-1",    16'h8000, 16'hFFFF,   17, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_div("1234/0",    16'd1234, 16'h0000,    1, 16'hFFFF, 16'h04D2, 1'b0, 1'b1, 1'b0);

    // Reset in flight, with a stray start at cycle 5 that must be ignored.
    @(negedge clk);
    Dividend = 16'd1000; Divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    Dividend = 16'd5; Divisor = 16'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("ignored.busy", ready, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst.ready", ready, 1'b1);
    check("midrst.outs", {Quotient, Remainder}, 32'h0);
    check("midrst.flags", {Sign, DivByZero, Overflow}, 3'b000);
    @(negedge clk); reset = 1'b0;
    run_div("1000/3", 16'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    b2b[0] = '{a: 16'd50,    b: 16'd5,    q: 16'd10,   r: 16'd0,    s: 1'b0};
    b2b[1] = '{a: 16'hFF9C,  b: 16'd7,    q: 16'hFFF2, r: 16'hFFFE, s: 1'b1};
    b2b[2] = '{a: 16'h7FFF,  b: 16'h8000, q: 16'h0000, r: 16'h7FFF, s: 1'b1};
    @(negedge clk);
    Dividend = b2b[0].a; Divisor = b2b[0].b; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b%0d.accept", i), ready, 1'b0);
      if (i < 2) begin
        Dividend = b2b[i+1].a; Divisor = b2b[i+1].b;
      end else begin
        start = 1'b0;
      end
      wait_ready(lat);
      check_result($sformatf("b2b%0d", i), lat, 17, b2b[i].q, b2b[i].r, b2b[i].s, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    check("b2b.idle", ready, 1'b1);
    check("b2b.hold", Quotient, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
